// File: rtl/stq_forward_scheduler.sv
// Store-to-load forwarding age search shared by two load pipes: round-robin
// arbitration, two-stage age-masked priority select, single tagged response port.
module stq_forward_scheduler #(
  parameter int unsigned STQ_ENTRIES = 32,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_stq_enq,
  input  logic                   io_stq_flush,
  input  logic                   io_req_0_valid,
  output logic                   io_req_0_ready,
  input  logic [STQ_ENTRIES-1:0] io_req_0_bits_addr_matches,
  input  logic [TAG_W-1:0]       io_req_0_bits_tag,
  input  logic                   io_req_1_valid,
  output logic                   io_req_1_ready,
  input  logic [STQ_ENTRIES-1:0] io_req_1_bits_addr_matches,
  input  logic [TAG_W-1:0]       io_req_1_bits_tag,
  output logic                   io_resp_valid,
  input  logic                   io_resp_ready,
  output logic [TAG_W-1:0]       io_resp_bits_tag,
  output logic                   io_resp_bits_src,
  output logic                   io_resp_bits_hit,
  output logic [IDX_W-1:0]       io_resp_bits_forwarding_idx,
  output logic [IDX_W-1:0]       io_tail_idx,
  output logic                   io_busy
);

  function automatic logic [IDX_W-1:0] highest_set(input logic [STQ_ENTRIES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(STQ_ENTRIES); i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  logic [IDX_W-1:0]       tail_q, tail_d;
  logic                   rr_q, rr_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [STQ_ENTRIES-1:0] s1_matches_q, s1_matches_d;
  logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;
  logic                   s1_src_q, s1_src_d;
  logic [IDX_W-1:0]       s1_y_q, s1_y_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]       s2_tag_q, s2_tag_d;
  logic                   s2_src_q, s2_src_d;
  logic                   s2_hit_q, s2_hit_d;
  logic [IDX_W-1:0]       s2_idx_q, s2_idx_d;

  logic                   s1_adv, can_accept, win0, win1, accept;
  logic [STQ_ENTRIES-1:0] lo_mask, older;

  // Arbitration and accept; readies are held low while reset is asserted.
  always_comb begin
    s1_adv     = s1_valid_q && (!s2_valid_q || io_resp_ready);
    can_accept = reset && !io_stq_flush && (!s1_valid_q || s1_adv);
    win1       = io_req_1_valid && (!io_req_0_valid || rr_q);
    win0       = io_req_0_valid && !win1;
    accept     = can_accept && (win0 || win1);
  end

  assign io_req_0_ready = can_accept && win0;
  assign io_req_1_ready = can_accept && win1;

  // Entries strictly below the snapshotted tail are older; y=0 gives an empty mask.
  always_comb begin
    lo_mask = (STQ_ENTRIES'(1) << s1_y_q) - STQ_ENTRIES'(1);
    older   = s1_matches_q & lo_mask;
  end

  always_comb begin
    tail_d       = tail_q;
    rr_d         = rr_q;
    s1_valid_d   = s1_valid_q;
    s1_matches_d = s1_matches_q;
    s1_tag_d     = s1_tag_q;
    s1_src_d     = s1_src_q;
    s1_y_d       = s1_y_q;
    s2_valid_d   = s2_valid_q;
    s2_tag_d     = s2_tag_q;
    s2_src_d     = s2_src_q;
    s2_hit_d     = s2_hit_q;
    s2_idx_d     = s2_idx_q;

    if (io_stq_enq) tail_d = tail_q + IDX_W'(1);

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_tag_d   = s1_tag_q;
      s2_src_d   = s1_src_q;
      s2_hit_d   = |s1_matches_q;
      s2_idx_d   = (|older) ? highest_set(older) : highest_set(s1_matches_q);
    end else if (s2_valid_q && io_resp_ready) begin
      s2_valid_d = 1'b0;
    end

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_matches_d = win1 ? io_req_1_bits_addr_matches : io_req_0_bits_addr_matches;
      s1_tag_d     = win1 ? io_req_1_bits_tag : io_req_0_bits_tag;
      s1_src_d     = win1;
      s1_y_d       = tail_q;
      rr_d         = ~win1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Flush kills both stages and drops any pending response.
    if (io_stq_flush) begin
      tail_d     = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tail_q       <= '0;
      rr_q         <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_matches_q <= '0;
      s1_tag_q     <= '0;
      s1_src_q     <= 1'b0;
      s1_y_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= '0;
      s2_src_q     <= 1'b0;
      s2_hit_q     <= 1'b0;
      s2_idx_q     <= '0;
    end else begin
      tail_q       <= tail_d;
      rr_q         <= rr_d;
      s1_valid_q   <= s1_valid_d;
      s1_matches_q <= s1_matches_d;
      s1_tag_q     <= s1_tag_d;
      s1_src_q     <= s1_src_d;
      s1_y_q       <= s1_y_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      s2_src_q     <= s2_src_d;
      s2_hit_q     <= s2_hit_d;
      s2_idx_q     <= s2_idx_d;
    end
  end

  assign io_resp_valid               = s2_valid_q;
  assign io_resp_bits_tag            = s2_tag_q;
  assign io_resp_bits_src            = s2_src_q;
  assign io_resp_bits_hit            = s2_hit_q;
  assign io_resp_bits_forwarding_idx = s2_idx_q;
  assign io_tail_idx                 = tail_q;
  assign io_busy                     = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_stq_forward_scheduler.sv
// Directed bench for stq_forward_scheduler: hand-computed expectations per scenario.
module tb_stq_forward_scheduler;

  logic        clock;
  logic        reset;
  logic        io_stq_enq;
  logic        io_stq_flush;
  logic        io_req_0_valid;
  logic        io_req_0_ready;
  logic [31:0] io_req_0_bits_addr_matches;
  logic [3:0]  io_req_0_bits_tag;
  logic        io_req_1_valid;
  logic        io_req_1_ready;
  logic [31:0] io_req_1_bits_addr_matches;
  logic [3:0]  io_req_1_bits_tag;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [3:0]  io_resp_bits_tag;
  logic        io_resp_bits_src;
  logic        io_resp_bits_hit;
  logic [4:0]  io_resp_bits_forwarding_idx;
  logic [4:0]  io_tail_idx;
  logic        io_busy;

  int tests_run = 0;
  int tests_failed = 0;

  stq_forward_scheduler #(.STQ_ENTRIES(32), .IDX_W(5), .TAG_W(4)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_stq_enq                  (io_stq_enq),
    .io_stq_flush                (io_stq_flush),
    .io_req_0_valid              (io_req_0_valid),
    .io_req_0_ready              (io_req_0_ready),
    .io_req_0_bits_addr_matches  (io_req_0_bits_addr_matches),
    .io_req_0_bits_tag           (io_req_0_bits_tag),
    .io_req_1_valid              (io_req_1_valid),
    .io_req_1_ready              (io_req_1_ready),
    .io_req_1_bits_addr_matches  (io_req_1_bits_addr_matches),
    .io_req_1_bits_tag           (io_req_1_bits_tag),
    .io_resp_valid               (io_resp_valid),
    .io_resp_ready               (io_resp_ready),
    .io_resp_bits_tag            (io_resp_bits_tag),
    .io_resp_bits_src            (io_resp_bits_src),
    .io_resp_bits_hit            (io_resp_bits_hit),
    .io_resp_bits_forwarding_idx (io_resp_bits_forwarding_idx),
    .io_tail_idx                 (io_tail_idx),
    .io_busy                     (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request on a pipe for one cycle, then idle one cycle.
  task automatic send_one(input bit src, input logic [31:0] m, input logic [3:0] tag);
    if (src) begin
      io_req_1_valid = 1'b1; io_req_1_bits_addr_matches = m; io_req_1_bits_tag = tag;
    end else begin
      io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = m; io_req_0_bits_tag = tag;
    end
    step();
    io_req_0_valid = 1'b0;
    io_req_1_valid = 1'b0;
    step();
  endtask

  task automatic enq_n(input int n);
    io_stq_enq = 1'b1;
    repeat (n) step();
    io_stq_enq = 1'b0;
  endtask

  task automatic flush_one();
    io_stq_flush = 1'b1;
    step();
    io_stq_flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_req_0_valid = 1'b1;
    io_req_0_bits_addr_matches = 32'h1;
    #12;
    tests_run++;
    if (io_req_0_ready !== 1'b0 || io_req_1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b/%b want 0/0", io_req_0_ready, io_req_1_ready);
    end
    tests_run++;
    if ({io_resp_valid, io_busy, io_tail_idx, io_resp_bits_tag, io_resp_bits_src,
         io_resp_bits_hit, io_resp_bits_forwarding_idx} !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b busy=%b tail=%0d tag=%0d src=%b hit=%b idx=%0d want all 0",
               io_resp_valid, io_busy, io_tail_idx, io_resp_bits_tag, io_resp_bits_src,
               io_resp_bits_hit, io_resp_bits_forwarding_idx);
    end
    io_req_0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_select();
    enq_n(3);
    tests_run++;
    if (io_tail_idx !== 5'd3) begin
      tests_failed++;
      $display("FAIL basic_tail: got %0d want 3", io_tail_idx);
    end
    io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = 32'h0000_0025; io_req_0_bits_tag = 4'd5;
    #1;
    tests_run++;
    if (io_req_0_ready !== 1'b1 || io_req_1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ready: got %b/%b want 1/0", io_req_0_ready, io_req_1_ready);
    end
    step();
    io_req_0_valid = 1'b0;
    tests_run++;
    if (io_resp_valid !== 1'b0 || io_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency1: valid=%b busy=%b want 0/1", io_resp_valid, io_busy);
    end
    step();
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_hit,
         io_resp_bits_forwarding_idx} !== {1'b1, 4'd5, 1'b0, 1'b1, 5'd2}) begin
      tests_failed++;
      $display("FAIL basic_resp: valid=%b tag=%0d src=%b hit=%b idx=%0d want 1/5/0/1/2",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_hit,
               io_resp_bits_forwarding_idx);
    end
    step();
  endtask

  task automatic test_wrap_fallback();
    flush_one();
    enq_n(2);
    send_one(1'b1, 32'h8000_0010, 4'd9);
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_hit,
         io_resp_bits_forwarding_idx} !== {1'b1, 4'd9, 1'b1, 1'b1, 5'd31}) begin
      tests_failed++;
      $display("FAIL wrap_resp: valid=%b tag=%0d src=%b hit=%b idx=%0d want 1/9/1/1/31",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_hit,
               io_resp_bits_forwarding_idx);
    end
    send_one(1'b1, 32'h0000_0000, 4'd10);
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx}
        !== {1'b1, 4'd10, 1'b0, 5'd0}) begin
      tests_failed++;
      $display("FAIL nomatch_resp: valid=%b tag=%0d hit=%b idx=%0d want 1/10/0/0",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx);
    end
    step();
  endtask

  task automatic test_enq_race();
    enq_n(2);
    tests_run++;
    if (io_tail_idx !== 5'd4) begin
      tests_failed++;
      $display("FAIL race_tail_pre: got %0d want 4", io_tail_idx);
    end
    io_stq_enq = 1'b1;
    io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = 32'h10; io_req_0_bits_tag = 4'd6;
    step();
    io_stq_enq = 1'b0;
    io_req_0_valid = 1'b0;
    tests_run++;
    if (io_tail_idx !== 5'd5) begin
      tests_failed++;
      $display("FAIL race_tail_post: got %0d want 5", io_tail_idx);
    end
    step();
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx}
        !== {1'b1, 4'd6, 1'b1, 5'd4}) begin
      tests_failed++;
      $display("FAIL race_resp: valid=%b tag=%0d hit=%b idx=%0d want 1/6/1/4",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx);
    end
    step();
  endtask

  task automatic test_tail_wrap();
    flush_one();
    enq_n(31);
    tests_run++;
    if (io_tail_idx !== 5'd31) begin
      tests_failed++;
      $display("FAIL tail_31: got %0d want 31", io_tail_idx);
    end
    enq_n(1);
    tests_run++;
    if (io_tail_idx !== 5'd0) begin
      tests_failed++;
      $display("FAIL tail_wrap: got %0d want 0", io_tail_idx);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_tag;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = 32'h1; io_req_0_bits_tag = 4'hA;
    io_req_1_valid = 1'b1; io_req_1_bits_addr_matches = 32'h2; io_req_1_bits_tag = 4'hB;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) begin
        io_req_0_valid = 1'b0;
        io_req_1_valid = 1'b0;
        #1;
      end
      if (k < 6) begin
        #1;
        tests_run++;
        if (io_req_0_ready !== (k % 2 == 0) || io_req_1_ready !== (k % 2 == 1)) begin
          tests_failed++;
          $display("FAIL fair_grant[%0d]: got %b/%b want %b/%b", k, io_req_0_ready,
                   io_req_1_ready, (k % 2 == 0), (k % 2 == 1));
        end
      end
      if (k >= 2) begin
        exp_tag = ((k - 2) % 2 == 0) ? 4'hA : 4'hB;
        tests_run++;
        if ({io_resp_valid, io_resp_bits_src, io_resp_bits_tag, io_resp_bits_forwarding_idx}
            !== {1'b1, 1'((k - 2) % 2), exp_tag, 5'((k - 2) % 2)}) begin
          tests_failed++;
          $display("FAIL fair_resp[%0d]: valid=%b src=%b tag=%h idx=%0d want 1/%0d/%h/%0d", k,
                   io_resp_valid, io_resp_bits_src, io_resp_bits_tag,
                   io_resp_bits_forwarding_idx, (k - 2) % 2, exp_tag, (k - 2) % 2);
        end
      end
      step();
    end
    tests_run++;
    if (io_resp_valid !== 1'b0 || io_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fair_drain: valid=%b busy=%b want 0/0", io_resp_valid, io_busy);
    end
  endtask

  task automatic test_backpressure();
    io_resp_ready = 1'b0;
    io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = 32'h4; io_req_0_bits_tag = 4'd1;
    io_req_1_valid = 1'b1; io_req_1_bits_addr_matches = 32'h8; io_req_1_bits_tag = 4'd2;
    step();
    step();
    tests_run++;
    if (io_req_0_ready !== 1'b0 || io_req_1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_full: got %b/%b want 0/0", io_req_0_ready, io_req_1_ready);
    end
    step();
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_forwarding_idx}
        !== {1'b1, 4'd1, 1'b0, 5'd2} || io_req_0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold: valid=%b tag=%0d src=%b idx=%0d rdy0=%b want 1/1/0/2/0",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_src,
               io_resp_bits_forwarding_idx, io_req_0_ready);
    end
    io_req_0_valid = 1'b0;
    io_req_1_valid = 1'b0;
    io_resp_ready  = 1'b1;
    step();
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_forwarding_idx}
        !== {1'b1, 4'd2, 1'b1, 5'd3}) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%b tag=%0d src=%b idx=%0d want 1/2/1/3",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_src, io_resp_bits_forwarding_idx);
    end
    step();
    tests_run++;
    if (io_resp_valid !== 1'b0 || io_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_dup: valid=%b busy=%b want 0/0", io_resp_valid, io_busy);
    end
  endtask

  task automatic test_flush();
    io_stq_enq = 1'b1;
    io_req_0_valid = 1'b1; io_req_0_bits_addr_matches = 32'h1; io_req_0_bits_tag = 4'd3;
    step();
    io_req_0_valid = 1'b0;
    io_req_1_valid = 1'b1; io_req_1_bits_addr_matches = 32'h1; io_req_1_bits_tag = 4'd4;
    step();
    io_req_1_valid = 1'b0;
    io_req_0_valid = 1'b1; io_req_0_bits_tag = 4'd8;
    io_stq_flush = 1'b1;
    #1;
    tests_run++;
    if (io_resp_valid !== 1'b1 || io_busy !== 1'b1 || io_tail_idx !== 5'd2 ||
        io_req_0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_pre: valid=%b busy=%b tail=%0d rdy0=%b want 1/1/2/0",
               io_resp_valid, io_busy, io_tail_idx, io_req_0_ready);
    end
    step();
    io_stq_flush = 1'b0;
    io_stq_enq = 1'b0;
    io_req_0_valid = 1'b0;
    tests_run++;
    if (io_resp_valid !== 1'b0 || io_busy !== 1'b0 || io_tail_idx !== 5'd0) begin
      tests_failed++;
      $display("FAIL flush_post: valid=%b busy=%b tail=%0d want 0/0/0",
               io_resp_valid, io_busy, io_tail_idx);
    end
    step();
    tests_run++;
    if (io_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_resp: valid=%b want 0", io_resp_valid);
    end
    send_one(1'b0, 32'h3, 4'd12);
    tests_run++;
    if ({io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx}
        !== {1'b1, 4'd12, 1'b1, 5'd1}) begin
      tests_failed++;
      $display("FAIL flush_after: valid=%b tag=%0d hit=%b idx=%0d want 1/12/1/1",
               io_resp_valid, io_resp_bits_tag, io_resp_bits_hit, io_resp_bits_forwarding_idx);
    end
    step();
  endtask

  initial begin
    io_stq_enq = 1'b0;
    io_stq_flush = 1'b0;
    io_req_0_valid = 1'b0;
    io_req_0_bits_addr_matches = '0;
    io_req_0_bits_tag = '0;
    io_req_1_valid = 1'b0;
    io_req_1_bits_addr_matches = '0;
    io_req_1_bits_tag = '0;
    io_resp_ready = 1'b1;
    test_reset();
    test_basic_select();
    test_wrap_fallback();
    test_enq_race();
    test_tail_wrap();
    test_fairness();
    test_backpressure();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
